// File: rtl/dda_move_engine.sv
// DDA step generator: buffered moves drive per-axis accumulators whose
// increment ramps by a second-order term, emitting step/dir pulses.
module dda_move_engine #(
    parameter int NUM_AXES = 2,
    parameter int BUF_DEPTH = 4,
    parameter int ACC_W = 64,
    parameter int DIV_W = 8,
    parameter logic [ACC_W-1:0] STEP_THRESH = ACC_W'(64'h7fffffffffffff9b)
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    input  logic                      move_valid,
    output logic                      move_ready,
    input  logic [63:0]               move_duration,
    input  logic [NUM_AXES-1:0]       move_dir,
    input  logic [NUM_AXES*ACC_W-1:0] move_inc,
    input  logic [NUM_AXES*ACC_W-1:0] move_incinc,
    input  logic [DIV_W-1:0]          clock_divisor,
    input  logic                      halt,
    output logic [NUM_AXES-1:0]       step,
    output logic [NUM_AXES-1:0]       dir,
    output logic                      busy,
    output logic                      move_done,
    output logic [$clog2(BUF_DEPTH):0] buf_count
);
    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t state_q, state_d;

    logic [63:0]               mem_dur  [BUF_DEPTH];
    logic [NUM_AXES-1:0]       mem_dir  [BUF_DEPTH];
    logic [NUM_AXES*ACC_W-1:0] mem_inc  [BUF_DEPTH];
    logic [NUM_AXES*ACC_W-1:0] mem_iinc [BUF_DEPTH];

    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [63:0]      remaining;
    logic [DIV_W-1:0] div_q;
    logic [ACC_W-1:0] acc_q  [NUM_AXES];
    logic [ACC_W-1:0] inc_q  [NUM_AXES];
    logic [ACC_W-1:0] iinc_q [NUM_AXES];
    logic [ACC_W-1:0] nacc   [NUM_AXES];
    logic [NUM_AXES-1:0] fire;

    logic full, push, pop, tick, last_tick, zero_dur;

    always_comb begin
        full       = buf_count == CW'(BUF_DEPTH);
        move_ready = !wb_rst_i && !halt && !full;
        push       = move_valid && move_ready;
        pop        = state_q == LOAD;
        tick       = (state_q == RUN) && (div_q == '0);
        last_tick  = tick && (remaining == 64'd1);
        zero_dur   = mem_dur[rd_ptr] == 64'd0;
        busy       = state_q != IDLE;
    end

    // A positive running sum means at least one whole step is owed.
    always_comb begin
        for (int i = 0; i < NUM_AXES; i++) begin
            nacc[i] = acc_q[i] + inc_q[i];
            fire[i] = !nacc[i][ACC_W-1] && (nacc[i] != '0);
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (buf_count != '0) state_d = LOAD;
            LOAD: state_d = zero_dur ? IDLE : RUN;
            RUN:  if (last_tick) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (halt) state_d = IDLE;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge wb_clk_i) begin
        if (push) begin
            mem_dur[wr_ptr]  <= move_duration;
            mem_dir[wr_ptr]  <= move_dir;
            mem_inc[wr_ptr]  <= move_inc;
            mem_iinc[wr_ptr] <= move_incinc;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            buf_count <= '0;
            remaining <= '0;
            div_q     <= '0;
            dir       <= '0;
            step      <= '0;
            move_done <= 1'b0;
            for (int i = 0; i < NUM_AXES; i++) begin
                acc_q[i]  <= '0;
                inc_q[i]  <= '0;
                iinc_q[i] <= '0;
            end
        end else if (halt) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            buf_count <= '0;
            step      <= '0;
            move_done <= 1'b0;
            for (int i = 0; i < NUM_AXES; i++) begin
                acc_q[i] <= '0;
                inc_q[i] <= '0;
            end
        end else begin
            step      <= '0;
            move_done <= 1'b0;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            buf_count <= buf_count + CW'(push) - CW'(pop);
            if (state_q == LOAD) begin
                remaining <= mem_dur[rd_ptr];
                dir       <= mem_dir[rd_ptr];
                div_q     <= clock_divisor;
                move_done <= zero_dur;
                for (int i = 0; i < NUM_AXES; i++) begin
                    inc_q[i]  <= mem_inc[rd_ptr][i*ACC_W +: ACC_W];
                    iinc_q[i] <= mem_iinc[rd_ptr][i*ACC_W +: ACC_W];
                end
            end
            if (state_q == RUN) begin
                if (tick) begin
                    div_q     <= clock_divisor;
                    remaining <= remaining - 64'd1;
                    move_done <= last_tick;
                    step      <= fire;
                    for (int i = 0; i < NUM_AXES; i++) begin
                        inc_q[i] <= inc_q[i] + iinc_q[i];
                        acc_q[i] <= fire[i] ? nacc[i] - STEP_THRESH : nacc[i];
                    end
                end else begin
                    div_q <= div_q - 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_dda_move_engine.sv
// Bench for dda_move_engine: move-level reference model with a queue,
// per-cycle output compare, and scenario-level literal expectations.
module tb_dda_move_engine;
    localparam int NA = 2;
    localparam int D  = 4;
    localparam logic [63:0] TH = 64'h7fffffffffffff9b;

    typedef struct packed {
        logic [63:0]      dur;
        logic [NA-1:0]    dir;
        logic [NA*64-1:0] inc;
        logic [NA*64-1:0] iinc;
    } mv_t;

    logic clk = 1'b0;
    logic rst, move_valid, move_ready, halt, busy, move_done;
    logic [63:0] move_duration;
    logic [NA-1:0] move_dir, step, dir;
    logic [NA*64-1:0] move_inc, move_incinc;
    logic [7:0] clock_divisor;
    logic [2:0] buf_count;

    always #5 clk = ~clk;

    dda_move_engine dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .move_valid(move_valid), .move_ready(move_ready),
        .move_duration(move_duration), .move_dir(move_dir),
        .move_inc(move_inc), .move_incinc(move_incinc),
        .clock_divisor(clock_divisor), .halt(halt),
        .step(step), .dir(dir), .busy(busy),
        .move_done(move_done), .buf_count(buf_count)
    );

    // Reference: queue of pending moves plus the move in flight.
    mv_t q[$];
    int md;  // 0 waiting, 1 fetching, 2 executing
    longint unsigned m_rem;
    int m_div;
    logic signed [63:0] m_acc [NA];
    logic signed [63:0] m_inc [NA];
    logic signed [63:0] m_iinc [NA];
    logic [NA-1:0] e_step, e_dir;
    logic e_done;
    int tcount = 0;

    int checks = 0, failures = 0;
    bit chk_en = 0;
    int n_step0, n_step1, n_done;
    int st0[$];

    always @(posedge clk) begin
        bit acc_push;
        mv_t cur;
        logic signed [63:0] n;
        tcount++;
        acc_push = move_valid && !rst && !halt && q.size() < D;
        if (rst) begin
            q.delete(); md = 0; m_rem = 0; m_div = 0;
            e_step = '0; e_dir = '0; e_done = 0;
            for (int i = 0; i < NA; i++) begin
                m_acc[i] = 0; m_inc[i] = 0; m_iinc[i] = 0;
            end
        end else if (halt) begin
            q.delete(); md = 0; e_step = '0; e_done = 0;
            for (int i = 0; i < NA; i++) begin
                m_acc[i] = 0; m_inc[i] = 0;
            end
        end else begin
            e_step = '0; e_done = 0;
            if (md == 0) begin
                if (q.size() != 0) md = 1;
            end else if (md == 1) begin
                cur = q.pop_front();
                m_rem = cur.dur; e_dir = cur.dir; m_div = int'(clock_divisor);
                for (int i = 0; i < NA; i++) begin
                    m_inc[i] = cur.inc[i*64 +: 64];
                    m_iinc[i] = cur.iinc[i*64 +: 64];
                end
                if (cur.dur == 0) begin e_done = 1; md = 0; end
                else md = 2;
            end else begin
                if (m_div == 0) begin
                    for (int i = 0; i < NA; i++) begin
                        n = m_acc[i] + m_inc[i];
                        m_inc[i] = m_inc[i] + m_iinc[i];
                        if (n > 0) begin m_acc[i] = n - TH; e_step[i] = 1'b1; end
                        else m_acc[i] = n;
                    end
                    m_div = int'(clock_divisor);
                    m_rem = m_rem - 1;
                    if (m_rem == 0) begin e_done = 1; md = 0; end
                end else m_div = m_div - 1;
            end
            if (acc_push) q.push_back({move_duration, move_dir, move_inc, move_incinc});
        end
    end

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) if (chk_en) begin
        logic e_ready;
        e_ready = !rst && !halt && (q.size() < D);
        cmp("move_ready", 64'(move_ready), 64'(e_ready));
        cmp("buf_count", 64'(buf_count), 64'(q.size()));
        cmp("busy", 64'(busy), 64'(md != 0));
        cmp("step", 64'(step), 64'(e_step));
        cmp("dir", 64'(dir), 64'(e_dir));
        cmp("move_done", 64'(move_done), 64'(e_done));
        if (step[0] === 1'b1) begin n_step0++; st0.push_back(tcount); end
        if (step[1] === 1'b1) n_step1++;
        if (move_done === 1'b1) n_done++;
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic clr();
        n_step0 = 0; n_step1 = 0; n_done = 0; st0.delete();
    endtask

    task automatic do_reset();
        rst = 1; cyc(); cyc(); rst = 0; cyc();
    endtask

    task automatic set_move(input logic [63:0] dur, input logic [NA-1:0] d,
                            input logic [127:0] inc, input logic [127:0] iinc);
        move_duration = dur; move_dir = d; move_inc = inc; move_incinc = iinc;
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while (!(md == 0 && q.size() == 0) && n < max) begin cyc(); n++; end
        checks++;
        if (n >= max) begin
            failures++;
            $display("FAIL wait_idle actual=%0d cycles required<%0d", n, max);
        end
        repeat (3) cyc();
    endtask

    function automatic logic [63:0] rnd_iinc();
        logic signed [31:0] r;
        logic signed [63:0] w;
        r = $signed($urandom);
        w = r;
        return w <<< 24;
    endfunction

    function automatic logic [127:0] rnd_inc();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        int n;
        rst = 1; move_valid = 0; halt = 0; clock_divisor = 0;
        set_move(0, 0, 0, 0);
        @(posedge clk); #2;
        chk_en = 1;
        cyc(); rst = 0; cyc();

        // Single move: divisor 3, axis0 inc 2^62
        clr();
        clock_divisor = 3;
        set_move(10, 2'b01, {64'd0, 64'h4000000000000000}, '0);
        move_valid = 1; cyc(); move_valid = 0;
        wait_idle(200);
        cmp("A_steps0", 64'(n_step0), 64'd6);
        cmp("A_steps1", 64'(n_step1), 64'd0);
        cmp("A_done", 64'(n_done), 64'd1);
        cmp("A_busy", 64'(busy), 64'd0);

        // Accelerating move: incinc 2^58, divisor 0
        do_reset(); clr();
        clock_divisor = 0;
        set_move(16, 2'b00, '0, {64'd0, 64'h0400000000000000});
        move_valid = 1; cyc(); move_valid = 0;
        wait_idle(100);
        cmp("B_steps0", 64'(n_step0), 64'd4);
        for (int i = 2; i < st0.size(); i++)
            cmp("B_interval_shrink", 64'((st0[i] - st0[i-1]) <= (st0[i-1] - st0[i-2])), 64'd1);

        // Overfill while the first move stalls the engine
        do_reset(); clr();
        clock_divisor = 0;
        move_valid = 1;
        for (int k = 0; k < D + 2; k++) begin
            set_move(k == 0 ? 64'd1000 : 64'($urandom_range(1, 6)),
                     NA'($urandom), rnd_inc(), {rnd_iinc(), rnd_iinc()});
            cyc();
        end
        move_valid = 0;
        cmp("C_count_full", 64'(buf_count), 64'd4);
        cmp("C_ready_low", 64'(move_ready), 64'd0);
        wait_idle(3000);
        cmp("C_done", 64'(n_done), 64'd5);

        // Halt during tick 5 with two moves queued
        do_reset(); clr();
        clock_divisor = 0;
        move_valid = 1;
        set_move(20, 2'b10, {64'h4000000000000000, 64'h4000000000000000}, '0); cyc();
        set_move(7, 2'b01, rnd_inc(), '0); cyc();
        set_move(7, 2'b11, rnd_inc(), '0); cyc();
        move_valid = 0;
        n = 0;
        while (!(md == 2 && m_rem == 16) && n < 100) begin cyc(); n++; end
        cmp("D_reach_tick5", 64'(n < 100), 64'd1);
        halt = 1; cyc(); halt = 0;
        clr();
        repeat (10) cyc();
        cmp("D_count", 64'(buf_count), 64'd0);
        cmp("D_busy", 64'(busy), 64'd0);
        cmp("D_done", 64'(n_done), 64'd0);
        cmp("D_steps", 64'(n_step0 + n_step1), 64'd0);
        set_move(12, 2'b01, {64'd0, 64'h2000000000000000}, '0);
        move_valid = 1; cyc(); move_valid = 0;
        wait_idle(100);

        // Zero-duration move between two normal moves
        do_reset(); clr();
        clock_divisor = 1;
        move_valid = 1;
        set_move(4, 2'b01, rnd_inc(), '0); cyc();
        set_move(0, 2'b10, rnd_inc(), '0); cyc();
        set_move(4, 2'b11, rnd_inc(), '0); cyc();
        move_valid = 0;
        wait_idle(200);
        cmp("E_done", 64'(n_done), 64'd3);

        // One-cycle reset mid-move
        do_reset();
        clock_divisor = 1;
        set_move(50, 2'b11, rnd_inc(), '0);
        move_valid = 1; cyc(); move_valid = 0;
        repeat (20) cyc();
        rst = 1;
        @(negedge clk);
        cmp("R_ready_in_rst", 64'(move_ready), 64'd0);
        @(posedge clk); #2;
        rst = 0;
        @(negedge clk);
        cmp("R_step", 64'(step), 64'd0);
        cmp("R_dir", 64'(dir), 64'd0);
        cmp("R_busy", 64'(busy), 64'd0);
        cmp("R_done", 64'(move_done), 64'd0);
        cmp("R_count", 64'(buf_count), 64'd0);
        cmp("R_ready", 64'(move_ready), 64'd1);
        cyc();

        // Random traffic with occasional halts
        for (int k = 0; k < 400; k++) begin
            move_valid = ($urandom % 3) == 0;
            set_move(64'($urandom_range(0, 10)), NA'($urandom), rnd_inc(),
                     {rnd_iinc(), rnd_iinc()});
            clock_divisor = 8'($urandom_range(0, 3));
            halt = ($urandom % 50) == 0;
            cyc();
        end
        move_valid = 0; halt = 0;
        wait_idle(2000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
